hazard_scoreboard: RTL and testbench

- Parametrised pipeline hazard controller for the MIPS core; successor to the fixed 5-stage top-level, which has no interlocks and no forwarding.
- Tracks per-stage destination tags from EX through the last stage.
- Drives load-use stalls, branch squashes, and EX operand forwarding selects for a configurable-depth pipeline.
- Keeps saturating stall and flush counters for debug.

---
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Load-use stall, branch squash and EX operand-forwarding control
//          for a configurable-depth MIPS pipeline, with debug event counters.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int STAGES   = 5,
  parameter int BR_STAGE = 3,
  parameter int LOAD_LAT = 1,
  parameter int RA_W     = 5,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(STAGES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [RA_W-1:0]   id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              branch_taken,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic [STAGES-1:0] flush_mask,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int LW_TOP = 1 + LOAD_LAT;

  // Per-stage records for EX..WB. Source fields are only consulted in EX and
  // the load flag only inside the load-latency window, so only those are kept.
  logic [STAGES-1:2] r_valid;
  logic [STAGES-1:2] r_regwrite;
  logic [LW_TOP:2]   r_memread;
  logic [RA_W-1:0]   r_dest [2:STAGES-1];
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rt;
  logic              r_use_rs;
  logic              r_use_rt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_stall;
  logic w_flush;

  always_comb begin
    w_hz_rs = 1'b0;
    w_hz_rt = 1'b0;
    for (int s = 2; s <= LW_TOP; s++) begin
      if (r_valid[s] && r_memread[s] && (r_dest[s] == id_rs)) w_hz_rs = 1'b1;
      if (r_valid[s] && r_memread[s] && (r_dest[s] == id_rt)) w_hz_rt = 1'b1;
    end
    w_hz_rs = w_hz_rs & id_use_rs & (id_rs != '0);
    w_hz_rt = w_hz_rt & id_use_rt & (id_rt != '0);
  end

  // Gating with Reset keeps every hazard output quiet while reset is held.
  assign w_flush = Reset & branch_taken;
  assign w_stall = Reset & id_valid & (w_hz_rs | w_hz_rt) & ~branch_taken;

  assign pc_write_en   = ~w_stall;
  assign ifid_write_en = ~w_stall;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

  always_comb begin
    flush_mask = '0;
    for (int s = 1; s <= BR_STAGE; s++) flush_mask[s] = w_flush;
    if (w_stall) flush_mask[2] = 1'b1;
  end

  // Oldest match is written first so the youngest producer ends up selected.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    if (r_valid[2]) begin
      for (int s = STAGES - 1; s >= 3; s--) begin
        if (r_valid[s] && r_regwrite[s] && (r_dest[s] != '0)) begin
          if (r_use_rs && (r_dest[s] == r_rs)) fwd_sel_a = SEL_W'(s);
          if (r_use_rt && (r_dest[s] == r_rt)) fwd_sel_b = SEL_W'(s);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_valid     <= '0;
      r_regwrite  <= '0;
      r_memread   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_use_rs    <= 1'b0;
      r_use_rt    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      for (int s = 2; s <= STAGES - 1; s++) r_dest[s] <= '0;
    end else begin
      // Younger instructions up to the branch stage are squashed; the branch
      // itself moves on past BR_STAGE untouched.
      for (int s = 2; s <= STAGES - 2; s++) begin
        r_valid[s+1]    <= (s + 1 <= BR_STAGE) ? (r_valid[s] & ~branch_taken) : r_valid[s];
        r_regwrite[s+1] <= r_regwrite[s];
        r_dest[s+1]     <= r_dest[s];
      end
      for (int s = 2; s < LW_TOP; s++) r_memread[s+1] <= r_memread[s];

      r_valid[2]    <= id_valid & ~w_stall & ~branch_taken;
      r_regwrite[2] <= id_regwrite;
      r_memread[2]  <= id_memread;
      r_dest[2]     <= id_dest;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_use_rs      <= id_use_rs;
      r_use_rt      <= id_use_rt;

      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: a 5-stage and a 7-stage (LOAD_LAT=2, BR_STAGE=4, CNT_W=2)
// scoreboard share stimulus and are compared against a per-instruction pipeline model.
module tb_hazard_scoreboard;

  typedef struct packed { bit v; bit rw; bit mr; bit urs; bit urt; bit [4:0] d; bit [4:0] rs; bit [4:0] rt; } rec_t;
  typedef struct packed { bit v; bit [4:0] rs; bit [4:0] rt; bit urs; bit urt; bit [4:0] d; bit rw; bit mr; bit bt; } stim_t;

  localparam stim_t NOP = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, branch_taken;
  logic [4:0] id_rs, id_rt, id_dest;

  logic        pc5, ifid5, pc7, ifid7;
  logic [4:0]  mask5;
  logic [6:0]  mask7;
  logic [2:0]  fa5, fb5, fa7, fb7;
  logic [15:0] sc5, fc5;
  logic [1:0]  sc7, fc7;

  int n_run;
  int n_fail;

  int P_ST   [2] = '{5, 7};
  int P_LL   [2] = '{1, 2};
  int P_BR   [2] = '{3, 4};
  int P_CMAX [2] = '{65535, 3};

  rec_t mdl [2][8];
  int   m_sc [2];
  int   m_fc [2];

  always #5 clk = ~clk;

  hazard_scoreboard dut5 (
    .Clk(clk), .Reset(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .pc_write_en(pc5), .ifid_write_en(ifid5), .flush_mask(mask5),
    .fwd_sel_a(fa5), .fwd_sel_b(fb5), .stall_cnt(sc5), .flush_cnt(fc5)
  );

  hazard_scoreboard #(.STAGES(7), .BR_STAGE(4), .LOAD_LAT(2), .CNT_W(2)) dut7 (
    .Clk(clk), .Reset(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .pc_write_en(pc7), .ifid_write_en(ifid7), .flush_mask(mask7),
    .fwd_sel_a(fa7), .fwd_sel_b(fb7), .stall_cnt(sc7), .flush_cnt(fc7)
  );

  // ---------------- reference model ----------------
  function automatic void model_clear(int k);
    for (int s = 0; s < 8; s++) mdl[k][s] = '0;
    m_sc[k] = 0;
    m_fc[k] = 0;
  endfunction

  function automatic bit hz(int k, bit u, bit [4:0] src);
    if (!u || src == 5'd0) return 1'b0;
    for (int s = 2; s <= 1 + P_LL[k]; s++)
      if (mdl[k][s].v && mdl[k][s].mr && mdl[k][s].d == src) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall(int k);
    return rst_n && id_valid && !branch_taken && (hz(k, id_use_rs, id_rs) || hz(k, id_use_rt, id_rt));
  endfunction

  function automatic logic [2:0] fwd(int k, bit use_b);
    rec_t c;
    bit [4:0] src;
    bit u;
    c = mdl[k][2];
    src = use_b ? c.rt : c.rs;
    u = use_b ? c.urt : c.urs;
    if (!c.v || !u || src == 5'd0) return 3'd0;
    for (int s = 3; s < P_ST[k]; s++)
      if (mdl[k][s].v && mdl[k][s].rw && mdl[k][s].d == src) return 3'(s);
    return 3'd0;
  endfunction

  function automatic logic [47:0] expv(int k);
    logic [7:0] m;
    bit st;
    m = '0;
    st = exp_stall(k);
    if (rst_n && branch_taken) for (int s = 1; s <= P_BR[k]; s++) m[s] = 1'b1;
    if (st) m[2] = 1'b1;
    return {~st, ~st, m, fwd(k, 1'b0), fwd(k, 1'b1), 16'(m_sc[k]), 16'(m_fc[k])};
  endfunction

  function automatic logic [47:0] obs(int k);
    if (k == 0) return {pc5, ifid5, 3'b000, mask5, fa5, fb5, sc5, fc5};
    return {pc7, ifid7, 1'b0, mask7, fa7, fb7, 14'd0, sc7, 14'd0, fc7};
  endfunction

  function automatic void model_edge(int k);
    bit st;
    if (!rst_n) begin
      model_clear(k);
      return;
    end
    st = exp_stall(k);
    for (int s = P_ST[k] - 1; s >= 3; s--) begin
      mdl[k][s] = mdl[k][s-1];
      if (branch_taken && s <= P_BR[k]) mdl[k][s].v = 1'b0;
    end
    mdl[k][2] = '{v: id_valid && !st && !branch_taken, rw: id_regwrite, mr: id_memread,
                  urs: id_use_rs, urt: id_use_rt, d: id_dest, rs: id_rs, rt: id_rt};
    if (st && m_sc[k] < P_CMAX[k]) m_sc[k]++;
    if (branch_taken && m_fc[k] < P_CMAX[k]) m_fc[k]++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(stim_t s);
    id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs; id_use_rt = s.urt;
    id_dest = s.d; id_regwrite = s.rw; id_memread = s.mr; branch_taken = s.bt;
  endtask

  function automatic stim_t ins(bit [4:0] rs, bit urs, bit [4:0] rt, bit urt, bit [4:0] d, bit rw, bit mr);
    return '{v: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, d: d, rw: rw, mr: mr, bt: 1'b0};
  endfunction

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    drive(NOP);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t c;
    c = ins(9, 1, 9, 1, 3, 1, 1);
    c.bt = 1'b1;
    drive(c);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_run++;
      if (obs(k) !== expv(k)) begin
        n_fail++; $display("FAIL reset_vec stages=%0d: got %h expected %h", P_ST[k], obs(k), expv(k));
      end
    end
    n_run++;
    if ({pc5, ifid5, mask5, fa5, fb5, sc5, fc5} !== {2'b11, 5'b0, 6'b0, 32'b0}) begin
      n_fail++; $display("FAIL reset_outputs: got pc=%b ifid=%b mask=%b fa=%0d fb=%0d sc=%0d fc=%0d expected 1 1 0 0 0 0 0",
                         pc5, ifid5, mask5, fa5, fb5, sc5, fc5);
    end
    n_run++;
    if ({pc7, mask7} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_outputs7: got pc=%b mask=%b expected 1 0000000", pc7, mask7);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(NOP);
  endtask

  task automatic test_forward();
    stim_t seq [4];
    seq[0] = ins(1, 1, 2, 1, 8, 1, 0);
    seq[1] = ins(8, 1, 3, 1, 10, 1, 0);
    seq[2] = ins(8, 1, 0, 0, 11, 1, 0);
    seq[3] = NOP;
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL forward_vec stages=%0d step%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      if (i == 2) begin
        n_run++;
        if ({fa5, fa7, pc5, pc7} !== {3'd3, 3'd3, 2'b11}) begin
          n_fail++; $display("FAIL fwd_from_mem: got fa5=%0d fa7=%0d pc5=%b pc7=%b expected 3 3 1 1", fa5, fa7, pc5, pc7);
        end
      end
      if (i == 3) begin
        n_run++;
        if (fa5 !== 3'd4) begin
          n_fail++; $display("FAIL fwd_from_wb: got fa5=%0d expected 4", fa5);
        end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    stim_t seq [5];
    seq[0] = ins(1, 1, 0, 0, 9, 1, 1);
    seq[1] = ins(9, 1, 2, 1, 12, 1, 0);
    seq[2] = seq[1];
    seq[3] = seq[1];
    seq[4] = NOP;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL loaduse_vec stages=%0d step%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        n_run++;
        if ({pc5, ifid5, mask5, pc7} !== {2'b00, 5'b00100, 1'b0}) begin
          n_fail++; $display("FAIL loaduse_stall: got pc5=%b ifid5=%b mask5=%b pc7=%b expected 0 0 00100 0", pc5, ifid5, mask5, pc7);
        end
      end
      if (i == 2) begin
        n_run++;
        if ({sc5, pc5, pc7} !== {16'd1, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL loaduse_one_cycle: got sc5=%0d pc5=%b pc7=%b expected 1 1 0", sc5, pc5, pc7);
        end
      end
      if (i == 3) begin
        n_run++;
        if ({fa5, pc7, sc7} !== {3'd4, 1'b1, 2'd2}) begin
          n_fail++; $display("FAIL loaduse_release: got fa5=%0d pc7=%b sc7=%0d expected 4 1 2", fa5, pc7, sc7);
        end
      end
      if (i == 4) begin
        n_run++;
        if (fa7 !== 3'd5) begin
          n_fail++; $display("FAIL loaduse_fwd7: got fa7=%0d expected 5", fa7);
        end
      end
      step();
    end
  endtask

  task automatic test_branch_hazard();
    stim_t seq [4];
    int sc_exp, fc_exp;
    sc_exp = 0;
    fc_exp = 0;
    seq[0] = ins(1, 1, 0, 0, 9, 1, 1);
    seq[1] = ins(9, 1, 2, 1, 12, 1, 0);
    seq[1].bt = 1'b1;
    seq[2] = ins(9, 1, 0, 0, 13, 1, 0);
    seq[3] = NOP;
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL branch_vec stages=%0d step%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        sc_exp = m_sc[0];
        fc_exp = m_fc[0] + 1;
        n_run++;
        if ({mask5, mask7, pc5, pc7} !== {5'b01110, 7'b0011110, 2'b11}) begin
          n_fail++; $display("FAIL branch_mask: got mask5=%b mask7=%b pc5=%b pc7=%b expected 01110 0011110 1 1", mask5, mask7, pc5, pc7);
        end
      end
      if (i == 2) begin
        n_run++;
        if ({sc5, fc5, pc5, pc7} !== {16'(sc_exp), 16'(fc_exp), 2'b11}) begin
          n_fail++; $display("FAIL branch_counters: got sc5=%0d fc5=%0d pc5=%b pc7=%b expected %0d %0d 1 1", sc5, fc5, pc5, pc7, sc_exp, fc_exp);
        end
      end
      if (i == 3) begin
        n_run++;
        if ({fa5, fa7} !== 6'd0) begin
          n_fail++; $display("FAIL branch_squashed_fwd: got fa5=%0d fa7=%0d expected 0 0", fa5, fa7);
        end
      end
      step();
    end
  endtask

  task automatic test_zero_reg();
    stim_t seq [9];
    seq[0] = ins(1, 1, 2, 1, 7, 1, 0);
    seq[1] = ins(1, 1, 2, 1, 0, 1, 0);
    seq[2] = ins(0, 1, 7, 1, 14, 1, 0);
    seq[3] = seq[0];
    seq[4] = seq[0];
    seq[5] = ins(7, 1, 0, 0, 15, 1, 0);
    seq[6] = ins(1, 1, 0, 0, 0, 1, 1);
    seq[7] = ins(0, 1, 0, 1, 16, 1, 0);
    seq[8] = NOP;
    for (int i = 0; i < 9; i++) begin
      drive(seq[i]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL zero_vec stages=%0d step%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      if (i == 3) begin
        n_run++;
        if ({fa5, fb5, fa7, fb7} !== {3'd0, 3'd4, 3'd0, 3'd4}) begin
          n_fail++; $display("FAIL zero_no_fwd: got fa5=%0d fb5=%0d fa7=%0d fb7=%0d expected 0 4 0 4", fa5, fb5, fa7, fb7);
        end
      end
      if (i == 6) begin
        n_run++;
        if ({fa5, fa7} !== {3'd3, 3'd3}) begin
          n_fail++; $display("FAIL youngest_wins: got fa5=%0d fa7=%0d expected 3 3", fa5, fa7);
        end
      end
      if (i == 7) begin
        n_run++;
        if ({pc5, pc7} !== 2'b11) begin
          n_fail++; $display("FAIL zero_no_stall: got pc5=%b pc7=%b expected 1 1", pc5, pc7);
        end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    stim_t seq [5];
    seq[0] = ins(1, 1, 0, 0, 9, 1, 1);
    seq[1] = ins(9, 1, 2, 1, 12, 1, 0);
    seq[2] = seq[1];
    seq[3] = seq[1];
    seq[4] = NOP;
    seq[4].bt = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive(seq[i]);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          n_run++;
          if (obs(k) !== expv(k)) begin
            n_fail++; $display("FAIL sat_vec stages=%0d round%0d step%0d: got %h expected %h", P_ST[k], r, i, obs(k), expv(k));
          end
        end
        step();
      end
    end
    drive(NOP);
    @(negedge clk);
    n_run++;
    if ({sc7, fc7} !== 4'b1111) begin
      n_fail++; $display("FAIL counter_saturate: got sc7=%0d fc7=%0d expected 3 3", sc7, fc7);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stim_t s;
      s.v   = ($urandom_range(0, 3) != 0);
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.urs = $urandom_range(0, 1) != 0;
      s.urt = $urandom_range(0, 1) != 0;
      s.d   = 5'($urandom_range(0, 3));
      s.rw  = $urandom_range(0, 3) != 0;
      s.mr  = $urandom_range(0, 2) == 0;
      s.bt  = $urandom_range(0, 7) == 0;
      drive(s);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL random_vec stages=%0d cyc%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    stim_t c;
    drive(ins(1, 1, 2, 1, 5, 1, 0));
    @(negedge clk);
    step();
    drive(ins(5, 1, 2, 1, 5, 1, 0));
    @(negedge clk);
    step();
    c = ins(5, 1, 5, 1, 6, 1, 0);
    c.bt = 1'b1;
    drive(c);
    @(negedge clk);
    n_run++;
    if (fa5 !== 3'd3) begin
      n_fail++; $display("FAIL pre_reset_fwd: got fa5=%0d expected 3", fa5);
    end
    rst_n = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    n_run++;
    if ({pc5, ifid5, mask5, fa5, fb5, sc5, fc5} !== {2'b11, 5'b0, 6'b0, 32'b0}) begin
      n_fail++; $display("FAIL midreset_outputs: got pc=%b ifid=%b mask=%b fa=%0d fb=%0d sc=%0d fc=%0d expected 1 1 0 0 0 0 0",
                         pc5, ifid5, mask5, fa5, fb5, sc5, fc5);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL midreset_hold stages=%0d cyc%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      step();
    end
    rst_n = 1'b1;
    c.bt = 1'b0;
    drive(c);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs(k) !== expv(k)) begin
          n_fail++; $display("FAIL post_reset_vec stages=%0d cyc%0d: got %h expected %h", P_ST[k], i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        n_run++;
        if ({fa5, fb5, fa7, fb7} !== 12'd0) begin
          n_fail++; $display("FAIL stale_fwd: got fa5=%0d fb5=%0d fa7=%0d fb7=%0d expected 0 0 0 0", fa5, fb5, fa7, fb7);
        end
      end
      step();
      drive(NOP);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    model_clear(0);
    model_clear(1);
    drive(NOP);
    test_reset();
    test_forward();
    idle(8);
    test_load_use();
    idle(8);
    test_branch_hazard();
    idle(8);
    test_zero_reg();
    idle(8);
    test_saturation();
    idle(8);
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
